// File: rtl/filbuf_pkg.sv
// ---------------------------------------------------------------------------
// filbuf_pkg
// Shared definitions for the filter-result buffer stream reader.
//   FILBUF_ADDR_W / FILBUF_DATA_W : default buffer address and word widths
//   ST_*                          : reader FSM state encoding
//   filbuf_word_t                 : one buffer word
// ---------------------------------------------------------------------------
package filbuf_pkg;

    localparam int FILBUF_ADDR_W = 14;
    localparam int FILBUF_DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef logic [FILBUF_DATA_W-1:0] filbuf_word_t;

endpackage

// File: rtl/filbuf_skid_fifo.sv
// ---------------------------------------------------------------------------
// filbuf_skid_fifo
// Two-entry FIFO that absorbs the one-cycle BRAM read latency in front of
// the stream output. Push and pop in the same cycle leave the count unchanged.
// Ports:
//   clk_sys    in   clock
//   rst_b      in   asynchronous active-low reset (clears contents to zero)
//   push       in   write push_data this cycle
//   push_data  in   W-bit entry
//   pop        in   discard the head entry this cycle
//   head       out  oldest entry (valid when count != 0)
//   count      out  number of entries held (0..2)
// ---------------------------------------------------------------------------
module filbuf_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk_sys,
    input  logic         rst_b,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         rd_idx;
    logic         wr_idx;
    logic         push_ok;
    logic         pop_ok;

    assign pop_ok  = pop && (count != 2'd0);
    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign push_ok = push && ((count != 2'd2) || pop_ok);
    assign head    = rd_idx ? mem1 : mem0;

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_idx <= 1'b0;
            wr_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                if (wr_idx) mem1 <= push_data;
                else        mem0 <= push_data;
                wr_idx <= ~wr_idx;
            end
            if (pop_ok) rd_idx <= ~rd_idx;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/filbuf_stream_reader.sv
// ---------------------------------------------------------------------------
// filbuf_stream_reader
// Drains one frame from the filbuf BRAM (port B) and streams it out as an
// AXI4-Stream master, holding filbuf_wready low until the frame's last beat
// has been accepted.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | buffer free, waiting for frame_done with a non-zero length
//   ST_READ  | issuing BRAM reads for words 0..len-1
//   ST_DRAIN | all reads issued, waiting for the tlast handshake
//
// Ports:
//   s_axi_aclk, s_axi_aresetn     clock, async active-low reset
//   frame_done, frame_words       frame-complete pulse and its word count
//   filbuf_wready                 1 = writer may fill the buffer
//   filbuf_rden/rdaddr/rddata     BRAM port B (1-cycle read latency)
//   m_axis_tvalid/tready/tdata/tlast  stream output
//   busy                          1 while not idle
//   frame_overrun                 sticky: frame_done seen while busy
// ---------------------------------------------------------------------------
module filbuf_stream_reader
    import filbuf_pkg::*;
#(
    parameter int ADDR_W = FILBUF_ADDR_W,
    parameter int DATA_W = FILBUF_DATA_W
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              frame_done,
    input  logic [ADDR_W:0]   frame_words,
    output logic              filbuf_wready,
    output logic              filbuf_rden,
    output logic [ADDR_W-1:0] filbuf_rdaddr,
    input  logic [DATA_W-1:0] filbuf_rddata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              frame_overrun
);

    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [1:0]      state;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] rd_ptr;
    logic            inflight;
    logic            inflight_last;
    logic [1:0]      fifo_count;
    logic [DATA_W:0] fifo_head;
    logic            pop;
    logic [2:0]      occupancy;
    logic [2:0]      credit_limit;

    assign pop           = m_axis_tvalid && m_axis_tready;
    assign m_axis_tvalid = (fifo_count != 2'd0);
    assign m_axis_tdata  = fifo_head[DATA_W-1:0];
    assign m_axis_tlast  = fifo_head[DATA_W];
    assign busy          = (state != ST_IDLE);

    // Words held plus the read still in flight must fit the two FIFO slots
    // after this cycle's pop; counting the pop keeps 1 word/clk with tready high.
    assign occupancy     = {1'b0, fifo_count} + {2'b00, inflight};
    assign credit_limit  = 3'd2 + {2'b00, pop};
    assign filbuf_rden   = (state == ST_READ) && (rd_ptr < len) && (occupancy < credit_limit);
    // rd_ptr reaches 2**ADDR_W only after the final read, so the low bits never wrap mid-frame.
    assign filbuf_rdaddr = rd_ptr[ADDR_W-1:0];

    filbuf_skid_fifo #(
        .W (DATA_W + 1)
    ) u_skid_fifo (
        .clk_sys   (s_axi_aclk),
        .rst_b     (s_axi_aresetn),
        .push      (inflight),
        .push_data ({inflight_last, filbuf_rddata}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state         <= ST_IDLE;
            len           <= '0;
            rd_ptr        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            filbuf_wready <= 1'b1;
            frame_overrun <= 1'b0;
        end else begin
            inflight      <= filbuf_rden;
            inflight_last <= filbuf_rden && ((rd_ptr + PTR_ONE) == len);
            if (filbuf_rden) rd_ptr <= rd_ptr + PTR_ONE;
            if (frame_done && (state != ST_IDLE)) frame_overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (frame_done && (frame_words != '0)) begin
                        len           <= frame_words;
                        rd_ptr        <= '0;
                        filbuf_wready <= 1'b0;
                        state         <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_ptr == len) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop && m_axis_tlast) begin
                        filbuf_wready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filbuf_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_filbuf_stream_reader
// Directed bench for filbuf_stream_reader. A per-frame queue of expected
// beats is built from the frame length, and a negedge process compares the
// stream, BRAM reads and status outputs against it every cycle.
// ---------------------------------------------------------------------------
module tb_filbuf_stream_reader;
    import filbuf_pkg::*;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_done = 1'b0;
    logic [AW:0]   frame_words = '0;
    logic          wready;
    logic          rden;
    logic [AW-1:0] rdaddr;
    logic [DW-1:0] rddata = '0;
    logic          tvalid;
    logic          tready = 1'b1;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          busy;
    logic          overrun;

    always #5 clk = ~clk;

    filbuf_stream_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .frame_done    (frame_done),
        .frame_words   (frame_words),
        .filbuf_wready (wready),
        .filbuf_rden   (rden),
        .filbuf_rdaddr (rdaddr),
        .filbuf_rddata (rddata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tdata  (tdata),
        .m_axis_tlast  (tlast),
        .busy          (busy),
        .frame_overrun (overrun)
    );

    // BRAM contents: word at address a is a*3
    always @(posedge clk) if (rden) rddata <= DW'(rdaddr) * 32'd3;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic filbuf_word_t exp_word(input int i);
        return filbuf_word_t'(i * 3);
    endfunction

    // ---------------- model state ----------------
    logic [DW:0]   exp_q[$];
    bit            model_busy = 0;
    bit            exp_ovr = 0;
    int            rd_exp = 0;
    int            cur_len = 0;
    int            outstanding = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    int            cyc = 0;
    int            beats = 0;
    int            rden_cnt = 0;
    int            tvalid_cnt = 0;
    int            first_valid_cyc = -1;
    int            last_beat_cyc = 0;
    int            tlast_beat = 0;
    int            fd_cyc = 0;
    logic [AW-1:0] last_rdaddr = '0;
    logic [DW-1:0] beat_data [0:31];

    int            tready_mode = 0;
    int            pat_idx = 0;

    always @(negedge clk) begin
        bit busy_before;
        cyc++;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            busy_before = model_busy;
            check("busy", 64'(busy), 64'(model_busy));
            check("wready", 64'(wready), 64'(!model_busy));
            check("overrun", 64'(overrun), 64'(exp_ovr));
            if (prev_stall) begin
                check("stall_valid", 64'(tvalid), 64'(1));
                check("stall_data", 64'(tdata), 64'(prev_data));
                check("stall_last", 64'(tlast), 64'(prev_last));
            end
            if (rden) begin
                rden_cnt++;
                check("rden_in_frame", 64'(model_busy && (rd_exp < cur_len)), 64'(1));
                check("rdaddr", 64'(rdaddr), 64'(rd_exp[AW-1:0]));
                last_rdaddr = rdaddr;
                rd_exp++;
                outstanding++;
            end
            if (tvalid) begin
                tvalid_cnt++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: tvalid=1 tdata=%0h with no word due", tdata);
                end else begin
                    check("tdata", 64'(tdata), 64'(exp_q[0][DW-1:0]));
                    check("tlast", 64'(tlast), 64'(exp_q[0][DW]));
                end
                if (tready) begin
                    if (beats < 32) beat_data[beats] = tdata;
                    beats++;
                    if (tlast) tlast_beat = beats;
                    last_beat_cyc = cyc;
                    outstanding--;
                    if (exp_q.size() != 0) begin
                        if (exp_q[0][DW]) model_busy = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            check("outstanding_le_2", 64'(outstanding <= 2), 64'(1));
            if (frame_done) begin
                if (busy_before) begin
                    exp_ovr = 1;
                end else if (frame_words != '0) begin
                    model_busy = 1;
                    cur_len = int'(frame_words);
                    rd_exp = 0;
                    for (int i = 0; i < cur_len; i++)
                        exp_q.push_back({(i == cur_len - 1), exp_word(i)});
                end
            end
        end
    end

    // tready driver: always 1, or the repeating pattern 1,0,0,1
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tready_mode == 1) begin
                tready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
                pat_idx++;
            end else begin
                tready = 1'b1;
            end
        end
    end

    task automatic pulse_done(input int n, input bit new_frame);
        @(posedge clk);
        #1;
        frame_words = (AW+1)'(n);
        frame_done  = 1'b1;
        if (new_frame) begin
            fd_cyc = cyc + 1;
            beats = 0;
            tlast_beat = 0;
            first_valid_cyc = -1;
        end
        @(posedge clk);
        #1;
        frame_done = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((busy || model_busy) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= limit) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles", name, limit);
        end
    endtask

    task automatic wait_beats(input int b, input int limit, input string name);
        int n = 0;
        while (beats < b && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= limit) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: beats=%0d wanted %0d", name, beats, b);
        end
    endtask

    initial begin
        int r0;
        int v0;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_wready", 64'(wready), 64'(1));
        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_rden", 64'(rden), 64'(0));
        check("rst_rdaddr", 64'(rdaddr), 64'(0));
        check("rst_tdata", 64'(tdata), 64'(0));
        check("rst_tlast", 64'(tlast), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        #2 rst_n = 1'b1;

        // 1: len 8, tready high
        pulse_done(8, 1);
        check("t1_wready_low", 64'(wready), 64'(0));
        wait_idle(200, "t1");
        check("t1_beats", 64'(beats), 64'(8));
        check("t1_tlast_beat", 64'(tlast_beat), 64'(8));
        check("t1_data0", 64'(beat_data[0]), 64'(0));
        check("t1_data3", 64'(beat_data[3]), 64'(9));
        check("t1_data7", 64'(beat_data[7]), 64'(21));
        check("t1_latency", 64'(first_valid_cyc - fd_cyc), 64'(3));
        check("t1_back_to_back", 64'(last_beat_cyc - first_valid_cyc), 64'(7));
        check("t1_wready_back", 64'(wready), 64'(1));

        // 2: len 16, tready 1,0,0,1
        tready_mode = 1;
        pat_idx = 0;
        pulse_done(16, 1);
        wait_idle(400, "t2");
        tready_mode = 0;
        check("t2_beats", 64'(beats), 64'(16));
        check("t2_tlast_beat", 64'(tlast_beat), 64'(16));
        check("t2_data5", 64'(beat_data[5]), 64'(15));
        check("t2_data15", 64'(beat_data[15]), 64'(45));

        // 3: len 1, then len 0
        pulse_done(1, 1);
        wait_idle(100, "t3a");
        check("t3_beats", 64'(beats), 64'(1));
        check("t3_tlast_beat", 64'(tlast_beat), 64'(1));
        check("t3_data0", 64'(beat_data[0]), 64'(0));
        check("t3_wready", 64'(wready), 64'(1));
        r0 = rden_cnt;
        v0 = tvalid_cnt;
        pulse_done(0, 1);
        repeat (6) @(posedge clk);
        #1;
        check("t3_len0_rden", 64'(rden_cnt - r0), 64'(0));
        check("t3_len0_tvalid", 64'(tvalid_cnt - v0), 64'(0));
        check("t3_len0_wready", 64'(wready), 64'(1));
        check("t3_len0_busy", 64'(busy), 64'(0));

        // 4: maximum length
        pulse_done(16384, 1);
        wait_idle(20000, "t4");
        check("t4_beats", 64'(beats), 64'(16384));
        check("t4_tlast_beat", 64'(tlast_beat), 64'(16384));
        check("t4_last_rdaddr", 64'(last_rdaddr), 64'(14'h3FFF));
        check("t4_back_to_back", 64'(last_beat_cyc - first_valid_cyc), 64'(16383));

        // 5: overrun during a len 10 frame
        pulse_done(10, 1);
        wait_beats(3, 200, "t5");
        pulse_done(7, 0);
        check("t5_overrun", 64'(overrun), 64'(1));
        wait_idle(200, "t5");
        check("t5_beats", 64'(beats), 64'(10));
        check("t5_tlast_beat", 64'(tlast_beat), 64'(10));
        pulse_done(3, 1);
        wait_idle(200, "t5b");
        check("t5b_beats", 64'(beats), 64'(3));
        check("t5b_data2", 64'(beat_data[2]), 64'(6));
        check("t5b_overrun_sticky", 64'(overrun), 64'(1));

        // 6: reset in the middle of a len 20 frame
        pulse_done(20, 1);
        wait_beats(4, 200, "t6");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_tvalid", 64'(tvalid), 64'(0));
        check("t6_rden", 64'(rden), 64'(0));
        check("t6_wready", 64'(wready), 64'(1));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_overrun", 64'(overrun), 64'(0));
        exp_q.delete();
        model_busy = 0;
        exp_ovr = 0;
        outstanding = 0;
        rd_exp = 0;
        cur_len = 0;
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        pulse_done(4, 1);
        wait_idle(100, "t6b");
        check("t6b_beats", 64'(beats), 64'(4));
        check("t6b_tlast_beat", 64'(tlast_beat), 64'(4));
        check("t6b_data0", 64'(beat_data[0]), 64'(0));
        check("t6b_data3", 64'(beat_data[3]), 64'(9));

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
